// File: rtl/audio_pkg.sv
// Shared audio-path types and defaults for the voice mixer and the effects chain.
package audio_pkg;
  localparam int DEFAULT_NUM_VOICES = 8;
  localparam int DEFAULT_SAMPLE_W   = 16;

  typedef logic signed [DEFAULT_SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {IDLE, SCAN, REQ, OUT} mix_state_t;

  localparam sample_t SAMPLE_MAX = sample_t'(2**(DEFAULT_SAMPLE_W-1) - 1);
  localparam sample_t SAMPLE_MIN = sample_t'(-(2**(DEFAULT_SAMPLE_W-1)));
endpackage

// File: rtl/sat_clamp.sv
// Combinational signed saturation from a wide accumulator down to sample width.
module sat_clamp #(
  parameter int IN_W  = 19,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);
  localparam logic signed [IN_W-1:0] MAX_IN = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_IN = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    dout = din[OUT_W-1:0];
    if (din > MAX_IN) begin
      dout = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (din < MIN_IN) begin
      dout = {1'b1, {(OUT_W-1){1'b0}}};
    end
  end
endmodule

// File: rtl/voice_mix_scheduler.sv
// Per-sample frame sequencer: scans enabled voices, accumulates their samples and
// hands one saturated mix to the output stage.
//
//   state | meaning
//   IDLE  | waiting for a sample_tick rising edge
//   SCAN  | testing latched enable for voice idx
//   REQ   | requesting voice idx, waiting for voice_ack
//   OUT   | presenting the clamped mix until accepted
module voice_mix_scheduler
  import audio_pkg::*;
#(
  parameter int NUM_VOICES = DEFAULT_NUM_VOICES,
  parameter int SAMPLE_W   = DEFAULT_SAMPLE_W,
  parameter int IDX_W      = $clog2(NUM_VOICES),
  parameter int ACC_W      = SAMPLE_W + IDX_W
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       sample_tick,
  input  logic [NUM_VOICES-1:0]      voice_enable,
  output logic                       voice_req,
  output logic [IDX_W-1:0]           voice_idx,
  input  logic                       voice_ack,
  input  logic signed [SAMPLE_W-1:0] voice_data,
  output logic signed [SAMPLE_W-1:0] out_sample,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       overrun
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  mix_state_t                state, state_nxt;
  logic                      tick_q;
  logic                      tick_edge;
  logic [IDX_W-1:0]          idx;
  logic [NUM_VOICES-1:0]     en_lat;
  logic signed [ACC_W-1:0]   acc;
  logic signed [SAMPLE_W-1:0] clamp_out;

  assign tick_edge = sample_tick & ~tick_q;

  sat_clamp #(
    .IN_W  (ACC_W),
    .OUT_W (SAMPLE_W)
  ) u_sat_clamp (
    .din  (acc),
    .dout (clamp_out)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (tick_edge) state_nxt = SCAN;
      SCAN: begin
        if (en_lat[idx]) begin
          state_nxt = REQ;
        end else if (idx == LAST_IDX) begin
          state_nxt = OUT;
        end
      end
      REQ: begin
        if (voice_ack) begin
          state_nxt = (idx == LAST_IDX) ? OUT : SCAN;
        end
      end
      OUT: if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // voice_req is decoded from state so reset removes it without waiting for a clock.
  always_comb begin
    voice_req = 1'b0;
    busy      = 1'b0;
    voice_idx = idx;
    if (state == REQ) voice_req = 1'b1;
    if (state != IDLE) busy = 1'b1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      tick_q     <= 1'b0;
      idx        <= '0;
      en_lat     <= '0;
      acc        <= '0;
      out_sample <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      tick_q  <= sample_tick;
      overrun <= tick_edge && (state != IDLE);
      case (state)
        IDLE: begin
          if (tick_edge) begin
            en_lat <= voice_enable;
            acc    <= '0;
            idx    <= '0;
          end
        end
        SCAN: begin
          if (!en_lat[idx] && (idx != LAST_IDX)) idx <= idx + 1'b1;
        end
        REQ: begin
          if (voice_ack) begin
            acc <= acc + {{IDX_W{voice_data[SAMPLE_W-1]}}, voice_data};
            if (idx != LAST_IDX) idx <= idx + 1'b1;
          end
        end
        OUT: begin
          // First OUT cycle captures the final accumulator, which includes the last ack.
          if (!out_valid) begin
            out_sample <= clamp_out;
            out_valid  <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_voice_mix_scheduler.sv
// Randomized self-checking bench for voice_mix_scheduler with a sum-and-clamp reference model.
module tb_voice_mix_scheduler;
  logic               Clk;
  logic               Reset;
  logic               sample_tick;
  logic [7:0]         voice_enable;
  logic               voice_req;
  logic [2:0]         voice_idx;
  logic               voice_ack;
  logic signed [15:0] voice_data;
  logic signed [15:0] out_sample;
  logic               out_valid;
  logic               out_ready;
  logic               busy;
  logic               overrun;

  int n_checks = 0;
  int n_errors = 0;

  int voice_val [8];
  int ack_delay = 0;
  bit spurious  = 0;
  int wait_cnt  = 0;
  int unstable  = 0;
  int req_cycles = 0;
  int ovr_cnt   = 0;
  logic [2:0] first_idx;
  int seen_q[$];

  voice_mix_scheduler dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .sample_tick  (sample_tick),
    .voice_enable (voice_enable),
    .voice_req    (voice_req),
    .voice_idx    (voice_idx),
    .voice_ack    (voice_ack),
    .voice_data   (voice_data),
    .out_sample   (out_sample),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .overrun      (overrun)
  );

  initial begin
    Clk = 0;
    forever #5 Clk = ~Clk;
  end

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Voice datapath responder: acks after ack_delay cycles, optionally acks junk while no request.
  initial begin
    voice_ack = 0;
    voice_data = '0;
    forever begin
      @(negedge Clk);
      voice_ack = 0;
      if (voice_req) begin
        req_cycles++;
        if (wait_cnt == 0) first_idx = voice_idx;
        else if (voice_idx != first_idx) unstable++;
        if (wait_cnt == ack_delay) begin
          voice_ack = 1;
          voice_data = 16'(voice_val[voice_idx]);
          seen_q.push_back(int'(voice_idx));
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
        if (spurious) begin
          voice_ack = 1;
          voice_data = 16'sd5000;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge Clk);
      if (overrun === 1'b1) ovr_cnt++;
    end
  end

  function automatic int model_mix(input logic [7:0] en);
    int sum = 0;
    for (int i = 0; i < 8; i++) if (en[i]) sum += voice_val[i];
    if (sum > 32767) sum = 32767;
    if (sum < -32768) sum = -32768;
    return sum;
  endfunction

  // Runs one frame, checks latency, mix, request order and handshake; toggles enables mid-frame if asked.
  task automatic frame(input logic [7:0] en, input int dly, input bit toggle, input string tag,
                       input bit accept);
    int lat;
    int nen;
    int ovr0;
    int exp_idx[$];
    voice_enable = en;
    ack_delay = dly;
    seen_q.delete();
    unstable = 0;
    req_cycles = 0;
    ovr0 = ovr_cnt;
    nen = 0;
    for (int i = 0; i < 8; i++) if (en[i]) begin nen++; exp_idx.push_back(i); end
    @(negedge Clk);
    sample_tick = 1;
    lat = 0;
    while (!out_valid && lat < 2000) begin
      @(negedge Clk);
      lat++;
      if (lat == 3) sample_tick = 0;
      if (toggle && lat == 4) voice_enable = ~en;
    end
    sample_tick = 0;
    spurious = 0;
    check_val({tag, "_lat"}, lat, 2 + 8 + nen * (1 + dly));
    check_val({tag, "_mix"}, out_sample, model_mix(en));
    check_val({tag, "_nreq"}, seen_q.size(), nen);
    check_val({tag, "_reqcyc"}, req_cycles, nen * (1 + dly));
    check_val({tag, "_idxstable"}, unstable, 0);
    check_val({tag, "_ovr"}, ovr_cnt - ovr0, 0);
    for (int k = 0; k < nen && k < seen_q.size(); k++)
      check_val({tag, "_order"}, seen_q[k], exp_idx[k]);
    if (accept) begin
      out_ready = 1;
      @(negedge Clk);
      out_ready = 0;
      check_val({tag, "_vld_drop"}, out_valid, 0);
      check_val({tag, "_idle"}, busy, 0);
    end
  endtask

  initial begin
    int changes;
    int busy_cnt;
    logic signed [15:0] held;
    Reset = 1;
    sample_tick = 0;
    voice_enable = '0;
    out_ready = 0;
    for (int i = 0; i < 8; i++) voice_val[i] = 0;
    repeat (3) @(negedge Clk);
    check_val("rst_req", voice_req, 0);
    check_val("rst_idx", voice_idx, 0);
    check_val("rst_sample", out_sample, 0);
    check_val("rst_valid", out_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_ovr", overrun, 0);
    Reset = 0;
    repeat (2) @(negedge Clk);

    voice_val[0] = 1000;
    voice_val[2] = -300;
    frame(8'b0000_0101, 0, 0, "basic", 1);

    for (int i = 0; i < 8; i++) voice_val[i] = 20000;
    frame(8'hFF, 0, 0, "satpos", 1);
    for (int i = 0; i < 8; i++) voice_val[i] = -20000;
    frame(8'hFF, 0, 0, "satneg", 1);

    frame(8'h00, 0, 0, "none", 1);

    for (int i = 0; i < 8; i++) voice_val[i] = int'($urandom_range(0, 20000)) - 10000;
    spurious = 1;
    frame(8'b1001_0110, 5, 1, "delay", 1);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 8; i++) voice_val[i] = int'($urandom_range(0, 65535)) - 32768;
      spurious = bit'($urandom_range(0, 1));
      frame(8'($urandom), $urandom_range(0, 3), bit'($urandom_range(0, 1)), "rand", 1);
    end

    // Stall the output across a second tick: exactly one dropped-tick pulse, mix held.
    for (int i = 0; i < 8; i++) voice_val[i] = int'($urandom_range(0, 8000)) - 4000;
    frame(8'b0011_1100, 0, 0, "stall", 0);
    held = out_sample;
    changes = 0;
    begin
      int ovr0 = ovr_cnt;
      for (int c = 0; c < 3000; c++) begin
        @(negedge Clk);
        if (c == 500) sample_tick = 1;
        if (c == 1000) sample_tick = 0;
        if (out_sample !== held || out_valid !== 1'b1) changes++;
      end
      check_val("stall_ovr", ovr_cnt - ovr0, 1);
    end
    check_val("stall_hold", changes, 0);
    out_ready = 1;
    @(negedge Clk);
    out_ready = 0;
    check_val("stall_vld_drop", out_valid, 0);
    busy_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clk);
      if (busy) busy_cnt++;
    end
    check_val("stall_nostart", busy_cnt, 0);
    frame(8'b1100_0001, 0, 0, "after_stall", 1);

    // Reset while waiting on an ack.
    voice_enable = 8'hFF;
    ack_delay = 10;
    @(negedge Clk);
    sample_tick = 1;
    begin
      int guard = 0;
      while (!voice_req && guard < 100) begin
        @(negedge Clk);
        guard++;
        sample_tick = 0;
      end
      check_val("rstmid_reached_req", voice_req, 1);
    end
    repeat (2) @(negedge Clk);
    Reset = 1;
    #1;
    check_val("rstmid_req", voice_req, 0);
    check_val("rstmid_busy", busy, 0);
    check_val("rstmid_valid", out_valid, 0);
    @(negedge Clk);
    Reset = 0;
    repeat (2) @(negedge Clk);
    for (int i = 0; i < 8; i++) voice_val[i] = int'($urandom_range(0, 20000)) - 10000;
    frame(8'b0101_1010, 1, 0, "post_rst", 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/voice_mix_scheduler.md
Name: voice_mix_scheduler

Overview:
- Per-sample frame sequencer for the synthesizer's voice datapath.
- On each rising edge of the 48 kHz sample-rate signal, it scans the enabled voices in index order and requests one sample per voice from the shared voice datapath over a req/ack handshake.
- It accumulates the returned samples, saturates the sum and presents one mixed sample to the audio output stage over a valid/ready handshake.

Parameters:
- NUM_VOICES, 8, number of voice slots; must be a power of two, ≥2.
- SAMPLE_W, 16, signed sample width for voice data and the mixed output.
- IDX_W, $clog2(NUM_VOICES), width of the voice index.
- ACC_W, SAMPLE_W+IDX_W, accumulator width; guarantees no internal overflow.

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset  in  1  asynchronous, active-high reset.
- sample_tick  in  1  48 kHz sample-rate level signal from the sample-rate counter; approx. 50% duty.
- voice_enable  in  NUM_VOICES  per-voice enable; bit i enables voice i.
- voice_req  out  1  request to the voice datapath for the voice on voice_idx.
- voice_idx  out  IDX_W  voice currently being requested.
- voice_ack  in  1  single-cycle acknowledge; voice_data is valid in the same cycle.
- voice_data  in  SAMPLE_W  signed sample returned for voice_idx.
- out_sample  out  SAMPLE_W  saturated signed mix.
- out_valid  out  1  out_sample valid; held until accepted.
- out_ready  in  1  downstream accept.
- busy  out  1  high whenever state ≠ IDLE.
- overrun  out  1  single-cycle pulse when a tick edge is dropped.

Behaviour:
- Clocking and reset: one clock domain, Clk. Reset is asynchronous and active-high; all flops clear immediately.
- Reset values:
  - voice_req=0, voice_idx=0, out_sample=0, out_valid=0, busy=0, overrun=0.
  - state=IDLE, accumulator=0, latched enable=0, tick-history flop=0.
- Tick detection: register sample_tick once (tick_q). tick_edge = sample_tick & ~tick_q. A level held high produces exactly one edge.
- FSM states: IDLE, SCAN, REQ, OUT.
- IDLE, on tick_edge:
  - latch voice_enable into en_lat; clear the accumulator; set idx=0; go to SCAN.
  - Changes to voice_enable mid-frame have no effect on the current frame.
- SCAN, one cycle per voice slot:
  - if en_lat[idx]=1, go to REQ;
  - else if idx=NUM_VOICES-1, go to OUT;
  - else idx+1 and stay in SCAN.
- REQ:
  - voice_req=1; voice_idx=idx, held stable until ack.
  - On voice_ack: acc += sign-extended voice_data; voice_req drops the next cycle.
  - Then, if idx=NUM_VOICES-1, go to OUT; else idx+1 and go to SCAN.
  - voice_ack while voice_req=0 is ignored. No timeout; REQ waits indefinitely.
- OUT:
  - out_sample = acc clamped to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1], registered on entry; out_valid=1.
  - out_sample stays stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready: out_valid=0 the next cycle; go to IDLE.
- All voices disabled: the frame still completes and outputs 0 with out_valid.
- Overrun: tick_edge while state≠IDLE gives overrun=1 for one cycle. The tick is dropped, with no queuing, and the current frame continues undisturbed.
- Frame latency, tick_edge to out_valid, zero-wait ack:
  - 1 (IDLE) + NUM_VOICES (SCAN) + 1 per enabled voice (REQ) + 1 cycle.
  - 18 cycles for 8 voices all enabled, well below the ~1042-cycle tick period.
- Reset mid-frame: everything returns to reset values immediately and voice_req drops asynchronously. A tick_edge in the first cycle after reset release is honoured only if tick_q (cleared by reset) and sample_tick=1.

Decomposition:
- Shared package audio_pkg:
  - NUM_VOICES and SAMPLE_W defaults;
  - typedef sample_t (signed [SAMPLE_W-1:0]);
  - state enum mix_state_t {IDLE, SCAN, REQ, OUT};
  - constants SAMPLE_MAX and SAMPLE_MIN.
- One sub-module, sat_clamp: combinational ACC_W → SAMPLE_W signed saturation. It is reused later by the effects chain.

Test Plan:
- Enable 8'b0000_0101; voice0 returns 1000 and voice2 returns -300, ack immediate; out_ready=1 → out_sample=700. voice_idx sequence 0 then 2; out_valid asserted 12 cycles after tick_edge.
- Enable all 8 voices, each returning 16'sd20000 → out_sample=32767. Same test with each returning -20000 → out_sample=-32768.
- Enable 0; tick_edge → out_sample=0, out_valid=1, no voice_req ever asserted.
- out_ready held 0 for 3000 cycles across a second tick_edge → overrun pulses exactly once; out_sample stable; after out_ready=1 the next frame starts only on the following tick_edge.
- voice_ack delayed 5 cycles; voice_enable toggled mid-frame; spurious ack while idle → voice_req and voice_idx stable during the wait; result uses the enables latched at frame start; spurious ack leaves the accumulator unchanged.
- Assert Reset during REQ → voice_req, busy and out_valid go to 0 the same cycle; after release the next tick_edge produces a correct fresh frame.
